fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fq_storage.sv | 31 +++
 rtl/fetch_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   INSTR_W / ADDR_W : instruction word and PC widths
//   HLT_OPCODE       : opcode field value (instr[15:12]) of the halt instruction
//   NOP_INSTR        : word presented to decode when nothing is valid
//   fq_entry_t       : one fetch-queue entry, {pc, instr}
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 16;

   localparam logic [3:0]         HLT_OPCODE = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4] == HLT_OPCODE;
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: DEPTH x {pc, instr}.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : entry written on the rising edge
//   raddr_i  : read index (combinational read)
//   rdata_o  : entry at raddr_i
// Contents are not reset; the owner masks reads while the queue is empty.
module fq_storage
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  fq_entry_t        wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output fq_entry_t        rdata_o
);

   fq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages.
//   clk, rst_n          : clock, async active-low reset
//   if_valid/if_ready   : enqueue handshake, with if_pc / if_instr payload
//   id_valid/id_ready   : dequeue handshake, with id_pc / id_instr head entry
//   flush               : redirect; empties the queue and re-opens enqueue
//   count               : occupied entries (0..DEPTH)
//   hlt                 : sticky; a halt instruction has been handed to decode
// Once a halt instruction is enqueued no further fetches are accepted until
// flush/reset, while the entries already queued keep draining.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_valid,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [INSTR_W-1:0] if_instr,
   output logic               if_ready,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INSTR_W-1:0] id_instr,
   input  logic               id_ready,
   input  logic               flush,
   output logic [PTR_W:0]     count,
   output logic               hlt
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             halt_seen_q, halt_seen_d;
   logic             hlt_q, hlt_d;

   logic      enq, deq;
   fq_entry_t wr_entry, head;

   // Ready/valid come from registered state only, so neither side sees a
   // combinational path from the other.
   assign if_ready = (count_q != FULL_CNT) && !halt_seen_q;
   assign id_valid = (count_q != '0);

   assign enq = if_valid && if_ready && !flush;
   assign deq = id_valid && id_ready && !flush;

   assign wr_entry = '{pc: if_pc, instr: if_instr};

   fq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
      .clk     (clk),
      .we_i    (enq),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // Storage is never reset, so stale words are masked while empty.
   assign id_pc    = id_valid ? head.pc    : '0;
   assign id_instr = id_valid ? head.instr : NOP_INSTR;
   assign count    = count_q;
   assign hlt      = hlt_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      halt_seen_d = halt_seen_q;
      hlt_d       = hlt_q;

      if (flush) begin
         // hlt is deliberately untouched: it reports retirement to decode.
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         halt_seen_d = 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;    // DEPTH is a power of two: wraps
            if (is_halt(if_instr)) halt_seen_d = 1'b1;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (is_halt(head.instr)) hlt_d = 1'b1;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         halt_seen_q <= 1'b0;
         hlt_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         halt_seen_q <= halt_seen_d;
         hlt_q       <= hlt_d;
      end
   end

endmodule
